// File: rtl/sp_arb_pkg.sv
// Shared types and default parameters for the single-port memory read/write arbiter.
package sp_arb_pkg;

    localparam int AW_DEF        = 8;
    localparam int DW_DEF        = 16;
    localparam int BURST_MAX_DEF = 4;
    localparam int RD_LAT_DEF    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_WR = 1'b0,
        SIDE_RD = 1'b1
    } side_t;

    function automatic side_t other_side(input side_t s);
        return (s == SIDE_WR) ? SIDE_RD : SIDE_WR;
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Delays the memory read enable by RD_LAT cycles to form the read-valid strobe.
module rd_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_en,
    output logic rd_valid
);

    logic [RD_LAT-1:0] pipe_reg;
    logic [RD_LAT-1:0] pipe_next;

    assign pipe_next[0] = rd_en;

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    endgenerate

    // Clearing on reset drops any read that was still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    assign rd_valid = pipe_reg[RD_LAT-1];

endmodule

// File: rtl/sp_mem_rw_arbiter.sv
// Round-robin burst arbiter sharing one single-port memory between a writer and a reader,
// with a one-cycle turnaround on direction changes.
module sp_mem_rw_arbiter
    import sp_arb_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_t    state_reg, state_next;
    side_t         last_served_reg, last_served_next;
    logic [CW-1:0] beat_cnt_reg, beat_cnt_next;
    logic          burst_done;
    side_t         turn_target;

    assign wr_gnt      = (state_reg == WR);
    assign rd_gnt      = (state_reg == RD);
    assign mem_wr_en   = wr_req & wr_gnt;
    assign mem_rd_en   = rd_req & rd_gnt;
    assign mem_addr    = wr_gnt ? wr_addr : (rd_gnt ? rd_addr : '0);
    assign mem_wdata   = wr_gnt ? wr_data : '0;
    assign rd_data     = mem_rdata;

    // A beat taken while the counter sits at BURST_MAX-1 completes the burst.
    assign burst_done  = (beat_cnt_reg == CW'(BURST_MAX - 1));
    assign turn_target = other_side(last_served_reg);

    always_comb begin
        state_next       = state_reg;
        last_served_next = last_served_reg;
        beat_cnt_next    = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (wr_req && rd_req) begin
                    state_next = (last_served_reg == SIDE_RD) ? WR : RD;
                end else if (wr_req) begin
                    state_next = WR;
                end else if (rd_req) begin
                    state_next = RD;
                end
            end
            WR: begin
                if (!wr_req) begin
                    state_next       = rd_req ? TURN : IDLE;
                    last_served_next = SIDE_WR;
                end else if (burst_done) begin
                    if (rd_req) begin
                        state_next       = TURN;
                        last_served_next = SIDE_WR;
                    end else begin
                        beat_cnt_next = '0;
                    end
                end else begin
                    beat_cnt_next = beat_cnt_reg + CW'(1);
                end
            end
            RD: begin
                if (!rd_req) begin
                    state_next       = wr_req ? TURN : IDLE;
                    last_served_next = SIDE_RD;
                end else if (burst_done) begin
                    if (wr_req) begin
                        state_next       = TURN;
                        last_served_next = SIDE_RD;
                    end else begin
                        beat_cnt_next = '0;
                    end
                end else begin
                    beat_cnt_next = beat_cnt_reg + CW'(1);
                end
            end
            TURN: begin
                if (turn_target == SIDE_WR) begin
                    state_next = wr_req ? WR : IDLE;
                end else begin
                    state_next = rd_req ? RD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state_reg) begin
            beat_cnt_next = '0;
        end
    end

    // last_served resets to the reader so the writer wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            last_served_reg <= SIDE_RD;
            beat_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            last_served_reg <= last_served_next;
            beat_cnt_reg    <= beat_cnt_next;
        end
    end

    rd_valid_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (mem_rd_en),
        .rd_valid(rd_valid)
    );

endmodule

// File: tb/tb_sp_mem_rw_arbiter.sv
// Self-checking bench for sp_mem_rw_arbiter: per-cycle vector table, hand sequences,
// and a read-return scoreboard backed by a simple latency-matched memory model.
module tb_sp_mem_rw_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 16;
    localparam int BURST_MAX = 4;
    localparam int RD_LAT    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt, rd_gnt, rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] rd_p1 = '0;

    typedef struct {
        logic          rst;
        logic          wr_req;
        logic          rd_req;
        logic [AW-1:0] wr_addr;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] wr_data;
        logic          exp_wr_gnt;
        logic          exp_rd_gnt;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    vec_t    vecs[$];
    rd_exp_t sb[$];
    rd_exp_t mon_e;
    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    int      step_idx = 0;
    bit      started  = 1'b0;

    sp_mem_rw_arbiter #(
        .AW(AW), .DW(DW), .BURST_MAX(BURST_MAX), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a == 8'h20) ? 16'hBEEF : {~a, a};
    endfunction

    // Memory macro stand-in with a two-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) rd_p1 <= mem_fn(mem_addr);
        mem_rdata <= rd_p1;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Monitor: mutual exclusion every cycle, read returns against the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            chk("mutex", cyc, {31'b0, mem_wr_en & mem_rd_en}, 32'd0);
            if (mem_wr_en === 1'b1)
                $display("cyc %0d write addr %h data %h", cyc, mem_addr, mem_wdata);
            if (rd_valid === 1'b1) begin
                $display("cyc %0d read return data %h", cyc, rd_data);
                if (sb.size() == 0) begin
                    chk("rd_valid_unexpected", cyc, 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rd_latency", cyc, cyc, mon_e.due);
                    chk("rd_data", cyc, {16'b0, rd_data}, {16'b0, mon_e.data});
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("rd_valid_missing", cyc, 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic apply(input vec_t v);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        rst     = v.rst;
        wr_req  = v.wr_req;
        rd_req  = v.rd_req;
        wr_addr = v.wr_addr;
        rd_addr = v.rd_addr;
        wr_data = v.wr_data;
        #1;
        ea = v.exp_wr_gnt ? v.wr_addr : (v.exp_rd_gnt ? v.rd_addr : '0);
        ed = v.exp_wr_gnt ? v.wr_data : '0;
        chk("wr_gnt", step_idx, {31'b0, wr_gnt}, {31'b0, v.exp_wr_gnt});
        chk("rd_gnt", step_idx, {31'b0, rd_gnt}, {31'b0, v.exp_rd_gnt});
        chk("mem_wr_en", step_idx, {31'b0, mem_wr_en}, {31'b0, v.exp_wr_gnt & v.wr_req});
        chk("mem_rd_en", step_idx, {31'b0, mem_rd_en}, {31'b0, v.exp_rd_gnt & v.rd_req});
        chk("mem_addr", step_idx, {24'b0, mem_addr}, {24'b0, ea});
        chk("mem_wdata", step_idx, {16'b0, mem_wdata}, {16'b0, ed});
        if (v.exp_rd_gnt && v.rd_req) sb.push_back('{data: mem_fn(v.rd_addr), due: cyc + RD_LAT});
        if (v.rst) sb.delete();
        step_idx++;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic wq, input logic rq,
                                input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                                input logic ewg, input logic erg);
        vec_t v;
        v.rst = r; v.wr_req = wq; v.rd_req = rq;
        v.wr_addr = wa; v.rd_addr = ra; v.wr_data = {~wa, wa ^ 8'h5A};
        v.exp_wr_gnt = ewg; v.exp_rd_gnt = erg;
        return v;
    endfunction

    task automatic step(input logic r, input logic wq, input logic rq,
                        input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                        input logic ewg, input logic erg);
        apply(mk(r, wq, rq, wa, ra, ewg, erg));
    endtask

    initial begin
        logic [AW-1:0] wa, ra;
        logic ewg, erg;
        rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 8'h30; rd_addr = 8'h40; wr_data = '0;
        @(posedge clk);
        #1;
        started = 1'b1;

        // Reset held with both requests high, then release: writer granted one cycle later.
        vecs.push_back(mk(1, 1, 1, 8'h30, 8'h40, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h30, 8'h40, 0, 0));
        // Contention: 4 writes, TURN, 4 reads, TURN, repeating.
        wa = 8'h30; ra = 8'h40;
        for (int i = 0; i < 19; i++) begin
            ewg = ((i % 10) < 4);
            erg = ((i % 10) >= 5) && ((i % 10) < 9);
            vecs.push_back(mk(0, 1, 1, wa, ra, ewg, erg));
            if (ewg) wa = wa + 8'd1;
            if (erg) ra = ra + 8'd1;
        end
        // TURN whose target dropped its request falls back to IDLE.
        vecs.push_back(mk(0, 0, 0, wa, ra, 0, 0));
        vecs.push_back(mk(0, 0, 0, wa, ra, 0, 0));
        // Write only: 6 beats at 0x10..0x15, burst wraps without a TURN.
        vecs.push_back(mk(0, 1, 0, 8'h10, ra, 0, 0));
        for (int a = 8'h10; a <= 8'h15; a++) vecs.push_back(mk(0, 1, 0, 8'(a), ra, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h15, ra, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h15, ra, 0, 0));
        // Single read of 0x20, returned RD_LAT cycles later.
        vecs.push_back(mk(0, 0, 1, 8'h15, 8'h20, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h15, 8'h20, 0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h15, 8'h20, 0, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 8'h15, 8'h20, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Early release after 2 writes: TURN, then a full 4-beat read burst.
        step(0, 1, 1, 8'h50, 8'h60, 0, 0);
        step(0, 1, 1, 8'h50, 8'h60, 1, 0);
        step(0, 1, 1, 8'h51, 8'h60, 1, 0);
        step(0, 0, 1, 8'h52, 8'h60, 1, 0);
        step(0, 1, 1, 8'h52, 8'h60, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 8'h52, 8'(8'h60 + i), 0, 1);
        step(0, 1, 1, 8'h52, 8'h64, 0, 0);
        step(0, 1, 1, 8'h52, 8'h64, 1, 0);
        step(0, 0, 0, 8'h53, 8'h64, 1, 0);
        step(0, 0, 0, 8'h53, 8'h64, 0, 0);

        // Reset one cycle after a read beat: the in-flight read never returns.
        step(0, 0, 1, 8'h00, 8'h70, 0, 0);
        step(0, 0, 1, 8'h00, 8'h70, 0, 1);
        step(1, 0, 1, 8'h00, 8'h70, 0, 1);
        chk("rd_valid_after_rst", step_idx, {31'b0, rd_valid}, 32'd0);
        step(0, 0, 0, 8'h00, 8'h70, 0, 0);
        chk("rd_valid_after_rst", step_idx, {31'b0, rd_valid}, 32'd0);
        step(0, 0, 0, 8'h00, 8'h70, 0, 0);
        step(0, 0, 0, 8'h00, 8'h70, 0, 0);

        chk("sb_drained", step_idx, sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
